// File: rtl/pcie_link_guard.sv
// Address-channel gatekeeper and link sequencer in front of the SoC->PCIe CDC.
// Define PCIE_LINK_GUARD_TIMEOUT_EN to build the drain timeout, FAULT escalation and isolation reset.
//
// state  | meaning
// IDLE   | link down or path disabled, gates closed
// TRAIN  | debouncing link_up_i && enable_i
// ACTIVE | gates open, requests admitted
// DRAIN  | gates closed, waiting for outstanding writes/reads to retire
// FAULT  | drain stalled, waiting for software to drop enable_i
module pcie_link_guard #(
   parameter int MaxOutstanding = 8,
   parameter int LinkDebounce   = 16,
   parameter int TimeoutCycles  = 1024
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  link_up_i,
   input  logic                                  enable_i,
   input  logic                                  slv_aw_valid_i,
   output logic                                  slv_aw_ready_o,
   output logic                                  mst_aw_valid_o,
   input  logic                                  mst_aw_ready_i,
   input  logic                                  slv_ar_valid_i,
   output logic                                  slv_ar_ready_o,
   output logic                                  mst_ar_valid_o,
   input  logic                                  mst_ar_ready_i,
   input  logic                                  b_valid_i,
   input  logic                                  b_ready_i,
   input  logic                                  r_valid_i,
   input  logic                                  r_ready_i,
   input  logic                                  r_last_i,
   output logic [2:0]                            state_o,
   output logic [$clog2(MaxOutstanding+1)-1:0]   wr_cnt_o,
   output logic [$clog2(MaxOutstanding+1)-1:0]   rd_cnt_o,
   output logic                                  timeout_o,
   output logic                                  iso_rst_o
);

   localparam int CW = $clog2(MaxOutstanding + 1);
   localparam int DW = (LinkDebounce > 1) ? $clog2(LinkDebounce) : 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(MaxOutstanding);
   localparam logic [DW-1:0] DEB_LAST = DW'(LinkDebounce - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TRAIN  = 3'd1,
      ACTIVE = 3'd2,
      DRAIN  = 3'd3,
      FAULT  = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] deb_q, deb_d;
   logic [CW-1:0] wr_q, wr_d;
   logic [CW-1:0] rd_q, rd_d;
   logic          cnt_clr;

   logic link_ok;
   logic open_aw, open_ar;
   logic aw_hs, ar_hs, b_hs, r_hs;
   logic b_eff, r_eff;

   assign link_ok = link_up_i & enable_i;

   // Gates depend only on registered state and counts.
   assign open_aw = (state_q == ACTIVE) && (wr_q < MAX_CNT);
   assign open_ar = (state_q == ACTIVE) && (rd_q < MAX_CNT);

   assign mst_aw_valid_o = slv_aw_valid_i & open_aw;
   assign slv_aw_ready_o = mst_aw_ready_i & open_aw;
   assign mst_ar_valid_o = slv_ar_valid_i & open_ar;
   assign slv_ar_ready_o = mst_ar_ready_i & open_ar;

   assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
   assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
   assign b_hs  = b_valid_i & b_ready_i;
   assign r_hs  = r_valid_i & r_ready_i & r_last_i;

   // Retirements with nothing outstanding are ignored so the counts saturate at zero.
   assign b_eff = b_hs && (wr_q != '0);
   assign r_eff = r_hs && (rd_q != '0);

`ifdef PCIE_LINK_GUARD_TIMEOUT_EN
   localparam int TW = $clog2(TimeoutCycles);
   localparam logic [TW-1:0] TO_LAST = TW'(TimeoutCycles - 1);

   logic [TW-1:0] to_q, to_d;
   logic          timeout_q;
   logic          iso_q;
`endif

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      cnt_clr = 1'b0;
`ifdef PCIE_LINK_GUARD_TIMEOUT_EN
      to_d    = to_q;
`endif
      case (state_q)
         IDLE: begin
            deb_d = '0;
            if (link_ok) state_d = TRAIN;
         end
         TRAIN: begin
            if (!link_ok) begin
               state_d = IDLE;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = ACTIVE;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + DW'(1);
            end
         end
         ACTIVE: begin
`ifdef PCIE_LINK_GUARD_TIMEOUT_EN
            to_d = '0;
`endif
            if (!link_ok) state_d = DRAIN;
         end
         DRAIN: begin
            // Even if the link is back, a drained path must retrain before reopening.
            if ((wr_q == '0) && (rd_q == '0)) begin
               state_d = IDLE;
            end
`ifdef PCIE_LINK_GUARD_TIMEOUT_EN
            else if (b_hs || r_hs) begin
               to_d = '0;
            end else if (to_q == TO_LAST) begin
               state_d = FAULT;
            end else begin
               to_d = to_q + TW'(1);
            end
`endif
         end
         FAULT: begin
            if (!enable_i) begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (cnt_clr) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (aw_hs && !b_eff)      wr_d = wr_q + CW'(1);
         else if (!aw_hs && b_eff) wr_d = wr_q - CW'(1);
         if (ar_hs && !r_eff)      rd_d = rd_q + CW'(1);
         else if (!ar_hs && r_eff) rd_d = rd_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         deb_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

`ifdef PCIE_LINK_GUARD_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_q      <= '0;
         timeout_q <= 1'b0;
         iso_q     <= 1'b0;
      end else begin
         to_q      <= to_d;
         timeout_q <= (state_d == FAULT);
         iso_q     <= (state_d == FAULT) && (state_q != FAULT);
      end
   end

   assign timeout_o = timeout_q;
   assign iso_rst_o = iso_q;
`else
   assign timeout_o = 1'b0;
   assign iso_rst_o = 1'b0;
`endif

   assign state_o  = state_q;
   assign wr_cnt_o = wr_q;
   assign rd_cnt_o = rd_q;

endmodule

// File: doc/pcie_link_guard.md
# pcie_link_guard

Address-channel gatekeeper and link sequencer for the SoC→PCIe AXI path. It sits in the SoC clock domain in front of the SoC→PCIe CDC. It only lets new AW/AR requests through once the XDMA link is up and stable. It tracks outstanding transactions, drains them cleanly when the link drops or software disables the path, and escalates to an isolation reset if draining stalls.

## Interface
Parameters:
- MaxOutstanding, 8: maximum in-flight writes, and separately in-flight reads; ≥1.
- LinkDebounce, 16: consecutive cycles of link_up_i && enable_i required before opening.
- TimeoutCycles, 1024: DRAIN cycles without any retirement before FAULT; ≥2.

Ports:
- clk_i  in  1  SoC clock.
- rst_i  in  1  reset, synchronous, active-high.
- link_up_i  in  1  XDMA link-up, already synchronized to clk_i.
- enable_i  in  1  software enable of the PCIe path.
- slv_aw_valid_i / slv_aw_ready_o  in/out  1  AW handshake from the SoC.
- mst_aw_valid_o / mst_aw_ready_i  out/in  1  AW handshake toward the CDC.
- slv_ar_valid_i / slv_ar_ready_o, mst_ar_valid_o / mst_ar_ready_i  as AW, for AR.
- b_valid_i, b_ready_i  in  1  observed B handshake, CDC side.
- r_valid_i, r_ready_i, r_last_i  in  1  observed R handshake, CDC side.
- state_o  out  3  current state encoding.
- wr_cnt_o, rd_cnt_o  out  $clog2(MaxOutstanding+1)  outstanding counts.
- timeout_o  out  1  sticky drain-timeout flag.
- iso_rst_o  out  1  one-cycle isolation-reset request.

## Operation
- States and encodings: IDLE=0, TRAIN=1, ACTIVE=2, DRAIN=3, FAULT=4.
- IDLE → TRAIN when link_up_i && enable_i.
- TRAIN: debounce counter increments each cycle while link_up_i && enable_i. Drops to 0 and returns to IDLE if either input falls. Reaching LinkDebounce-1 → ACTIVE.
- ACTIVE: gates open. !link_up_i || !enable_i → DRAIN.
- DRAIN: gates closed. When wr_cnt==0 && rd_cnt==0 → IDLE. This applies even if the link returns; re-entry always goes through TRAIN.
- FAULT: timeout_o=1. Stays until enable_i==0, then → IDLE with both counters cleared and timeout_o cleared.
- AW gating:
  - open_aw = (state==ACTIVE) && (wr_cnt < MaxOutstanding).
  - mst_aw_valid_o = slv_aw_valid_i & open_aw.
  - slv_aw_ready_o = mst_aw_ready_i & open_aw.
- AR gating: identical, using rd_cnt.
- The W channel is not gated; W beats belong to already-admitted AWs.
- wr_cnt: +1 on mst AW handshake, −1 on B handshake, unchanged when both occur in the same cycle. A B handshake at wr_cnt==0 is ignored (saturates at 0).
- rd_cnt: +1 on mst AR handshake, −1 on an R handshake with r_last_i. Same simultaneity and saturation rules as wr_cnt.
- Timeout counter:
  - Cleared on DRAIN entry and on any B or R-last retirement.
  - Increments each other DRAIN cycle.
  - Reaching TimeoutCycles-1 → FAULT.
  - iso_rst_o is high for the single cycle following FAULT entry.

## Timing
- State, counters and flags are registered. Gating is combinational from registered state and counts only; no path from link_up_i or enable_i to the valid/ready outputs.
- Gates close in the cycle after link_up_i or enable_i falls. An AW/AR handshake in that same falling cycle is still admitted and counted.
- Minimum IDLE→ACTIVE latency: LinkDebounce+1 cycles from link_up_i && enable_i first sampled high.
- Reset values:
  - state_o=IDLE(0), counters 0, timeout_o=0, iso_rst_o=0.
  - mst_aw_valid_o, mst_ar_valid_o, slv_aw_ready_o, slv_ar_ready_o all 0.
- Reset mid-transaction discards all counts. The surrounding AXI logic is reset together with this block.
- At wr_cnt==MaxOutstanding, a simultaneous B handshake does not reopen AW in that cycle; AW reopens the next cycle.

## Configuration
- PCIE_LINK_GUARD_TIMEOUT_EN defined: timeout counter, FAULT state, timeout_o and iso_rst_o are implemented as above.
- PCIE_LINK_GUARD_TIMEOUT_EN undefined:
  - DRAIN waits indefinitely for the counters to reach zero.
  - FAULT is unreachable.
  - timeout_o and iso_rst_o are tied to 0.

## Test plan
- Bring-up: link_up_i=1, enable_i=1 from reset with LinkDebounce=16 → state_o=2 at cycle 17. Earlier slv_aw_valid_i is held with slv_aw_ready_o=0.
- Debounce glitch: link_up_i drops at cycle 10 of TRAIN → state_o returns to 0; the full 16 cycles are required again.
- Throttle: issue 8 AWs with no B → 9th AW blocked, wr_cnt_o=8. One B → AW reopens the next cycle. Simultaneous AW and B at count 5 → count stays 5.
- Drain: 3 reads outstanding, enable_i→0 → state_o=3, AR gated. Three R-last handshakes → state_o=0, rd_cnt_o=0.
- Timeout (macro defined, TimeoutCycles=1024): 1 write outstanding, link drops, no B → FAULT after 1024 DRAIN cycles. timeout_o=1, iso_rst_o high exactly one cycle. enable_i=0 → IDLE, wr_cnt_o=0.
- Timeout (macro undefined): same stimulus → remains in DRAIN indefinitely (checked for 5000 cycles), timeout_o=0.
